// File: rtl/srec_write_packer_if.sv
// rtl/srec_write_packer_if.sv - parser byte stream in, memory write bus out
interface srec_write_packer_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [7:0]        in_data;
    logic              flush;
    logic [ADDR_W-1:0] address;
    logic [31:0]       data_in;
    logic              write;
    logic [1:0]        access_size;
    logic              idle;

    modport master (
        output in_valid, in_addr, in_data, flush,
        input  in_ready, address, data_in, write, access_size, idle
    );

    modport slave (
        input  in_valid, in_addr, in_data, flush,
        output in_ready, address, data_in, write, access_size, idle
    );
endinterface

// File: rtl/srec_write_packer.sv
// rtl/srec_write_packer.sv - coalesces byte writes into word writes; PACKER_HALFWORD_EN adds halfword drains
module srec_write_packer #(
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    srec_write_packer_if.slave   bus
);
    typedef enum logic {ACCUM, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:2] buf_word, buf_word_nxt;
    logic [31:0]       buf_data, buf_data_nxt;
    logic [3:0]        mask, mask_nxt;
    logic [ADDR_W-1:0] pend_addr, pend_addr_nxt;
    logic [7:0]        pend_data, pend_data_nxt;
    logic              pend_vld, pend_vld_nxt;
    logic [ADDR_W-1:0] address, address_nxt;
    logic [31:0]       data_in, data_in_nxt;
    logic              write, write_nxt;
    logic [1:0]        access_size, access_size_nxt;

    logic              accept;
    logic              same_word;
    logic [3:0]        lane_bit;
    logic [3:0]        mrg_mask;
    logic [31:0]       mrg_data;
    logic [ADDR_W-1:2] mrg_word;
    logic              sel_half;
    logic [1:0]        sel_lane;
    logic [3:0]        clr;
    logic [3:0]        left;

    // Lane 0 (addr[1:0]=0) is the most significant byte of the word.
    function automatic logic [31:0] set_lane(input logic [31:0] w, input logic [1:0] ln,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (ln)
            2'd0:    r[31:24] = b;
            2'd1:    r[23:16] = b;
            2'd2:    r[15:8]  = b;
            default: r[7:0]   = b;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] get_lane(input logic [31:0] w, input logic [1:0] ln);
        case (ln)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

    assign bus.in_ready    = (state == ACCUM);
    assign bus.address     = address;
    assign bus.data_in     = data_in;
    assign bus.write       = write;
    assign bus.access_size = access_size;
    assign bus.idle        = (state == ACCUM) && (mask == 4'h0) && !write;

    assign accept    = bus.in_valid && (state == ACCUM);
    assign same_word = (mask == 4'h0) || (bus.in_addr[ADDR_W-1:2] == buf_word);
    assign lane_bit  = 4'b0001 << bus.in_addr[1:0];

    // Next-state logic: merge/emit in ACCUM, one lane-group write per cycle in DRAIN.
    always_comb begin
        state_nxt       = state;
        buf_word_nxt    = buf_word;
        buf_data_nxt    = buf_data;
        mask_nxt        = mask;
        pend_addr_nxt   = pend_addr;
        pend_data_nxt   = pend_data;
        pend_vld_nxt    = pend_vld;
        address_nxt     = address;
        data_in_nxt     = data_in;
        write_nxt       = 1'b0;
        access_size_nxt = access_size;
        mrg_mask        = mask;
        mrg_data        = buf_data;
        mrg_word        = buf_word;
        sel_half        = 1'b0;
        sel_lane        = 2'd0;
        clr             = 4'h0;
        left            = mask;

        case (state)
            ACCUM: begin
                if (accept && same_word) begin
                    mrg_mask = mask | lane_bit;
                    mrg_data = set_lane(buf_data, bus.in_addr[1:0], bus.in_data);
                    mrg_word = bus.in_addr[ADDR_W-1:2];
                end
                if (accept && !same_word) begin
                    // Byte for another word waits in pend while the buffer drains.
                    pend_addr_nxt = bus.in_addr;
                    pend_data_nxt = bus.in_data;
                    pend_vld_nxt  = 1'b1;
                    state_nxt     = DRAIN;
                end else if (mrg_mask == 4'hF) begin
                    write_nxt       = 1'b1;
                    access_size_nxt = 2'b10;
                    address_nxt     = {mrg_word, 2'b00};
                    data_in_nxt     = mrg_data;
                    mask_nxt        = 4'h0;
                    buf_data_nxt    = 32'h0;
                end else begin
                    buf_word_nxt = mrg_word;
                    buf_data_nxt = mrg_data;
                    mask_nxt     = mrg_mask;
                    if (bus.flush && mrg_mask != 4'h0) begin
                        state_nxt = DRAIN;
                    end
                end
            end

            DRAIN: begin
`ifdef PACKER_HALFWORD_EN
                sel_half = (mask[1:0] == 2'b11) || (mask[1:0] == 2'b00 && mask[3:2] == 2'b11);
`endif
                sel_lane  = mask[0] ? 2'd0 : mask[1] ? 2'd1 : mask[2] ? 2'd2 : 2'd3;
                write_nxt = 1'b1;
                address_nxt = {buf_word, sel_lane};
                if (sel_half) begin
                    access_size_nxt = 2'b01;
                    data_in_nxt     = sel_lane[1] ? {16'h0, buf_data[15:0]} : {16'h0, buf_data[31:16]};
                    clr             = sel_lane[1] ? 4'b1100 : 4'b0011;
                end else begin
                    access_size_nxt = 2'b00;
                    data_in_nxt     = {24'h0, get_lane(buf_data, sel_lane)};
                    clr             = 4'b0001 << sel_lane;
                end
                left = mask & ~clr;
                if (left == 4'h0) begin
                    state_nxt    = ACCUM;
                    pend_vld_nxt = 1'b0;
                    if (pend_vld) begin
                        buf_word_nxt = pend_addr[ADDR_W-1:2];
                        buf_data_nxt = set_lane(32'h0, pend_addr[1:0], pend_data);
                        mask_nxt     = 4'b0001 << pend_addr[1:0];
                    end else begin
                        buf_data_nxt = 32'h0;
                        mask_nxt     = 4'h0;
                    end
                end else begin
                    mask_nxt = left;
                end
            end

            default: state_nxt = ACCUM;
        endcase
    end

    // State and output registers; reset discards buffer, pend and any write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ACCUM;
            buf_word    <= '0;
            buf_data    <= 32'h0;
            mask        <= 4'h0;
            pend_addr   <= '0;
            pend_data   <= 8'h0;
            pend_vld    <= 1'b0;
            address     <= '0;
            data_in     <= 32'h0;
            write       <= 1'b0;
            access_size <= 2'b00;
        end else begin
            state       <= state_nxt;
            buf_word    <= buf_word_nxt;
            buf_data    <= buf_data_nxt;
            mask        <= mask_nxt;
            pend_addr   <= pend_addr_nxt;
            pend_data   <= pend_data_nxt;
            pend_vld    <= pend_vld_nxt;
            address     <= address_nxt;
            data_in     <= data_in_nxt;
            write       <= write_nxt;
            access_size <= access_size_nxt;
        end
    end
endmodule

// File: tb/tb_srec_write_packer.sv
// tb/tb_srec_write_packer.sv - scoreboard bench for srec_write_packer
module tb_srec_write_packer;
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  s;
    } wr_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_miss;
    bit   mon_en;
    wr_t  sb_q[$];

    srec_write_packer_if #(.ADDR_W(32)) bus ();

    srec_write_packer #(.ADDR_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endfunction

    function automatic void expect_wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        wr_t w;
        w.a = a;
        w.d = d;
        w.s = s;
        sb_q.push_back(w);
    endfunction

    always @(negedge clk) begin
        if (mon_en && rst_n && bus.write) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_write", {bus.access_size, bus.address}, 64'hFFFF);
            end else begin
                wr_t w;
                w = sb_q.pop_front();
                chk("wr_addr", bus.address, w.a);
                chk("wr_data", bus.data_in, w.d);
                chk("wr_size", bus.access_size, w.s);
            end
        end
    end

    task automatic put(input logic [31:0] a, input logic [7:0] d, input bit fl);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_addr  = a;
        bus.in_data  = d;
        bus.flush    = fl;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", 1, 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.idle && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk(tag, 1, 0);
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        wait_idle("flush_timeout");
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
    endtask

    initial begin
        int cnt;
        n_vec        = 0;
        n_miss       = 0;
        mon_en       = 1'b1;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_addr  = 32'h0;
        bus.in_data  = 8'h0;
        bus.flush    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_address", bus.address, 0);
        chk("rst_data_in", bus.data_in, 0);
        chk("rst_write", bus.write, 0);
        chk("rst_size", bus.access_size, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_idle", bus.idle, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Full word from four consecutive bytes.
        expect_wr(32'h80020000, 32'h11223344, 2'b10);
        put(32'h80020000, 8'h11, 1'b0);
        put(32'h80020001, 8'h22, 1'b0);
        put(32'h80020002, 8'h33, 1'b0);
        put(32'h80020003, 8'h44, 1'b0);
        @(negedge clk);
        chk("t1_word_latency", bus.write, 1);
        wait_idle("t1_idle");

        // Word change forces a drain of the two held lanes.
        expect_wr(32'h80020001, 32'h000000AA, 2'b00);
        expect_wr(32'h80020002, 32'h000000BB, 2'b00);
        put(32'h80020001, 8'hAA, 1'b0);
        put(32'h80020002, 8'hBB, 1'b0);
        put(32'h80020010, 8'hCC, 1'b0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.in_ready) break;
            cnt++;
        end
        chk("t2_ready_low", cnt, 2);
        @(negedge clk);
        chk("t2_idle_held", bus.idle, 0);
        expect_wr(32'h80020010, 32'h000000CC, 2'b00);
        do_flush();
        chk("t2_idle_after", bus.idle, 1);

        // Three-lane partial word drained by flush.
`ifdef PACKER_HALFWORD_EN
        expect_wr(32'h80020004, 32'h00000102, 2'b01);
        expect_wr(32'h80020006, 32'h00000003, 2'b00);
`else
        expect_wr(32'h80020004, 32'h00000001, 2'b00);
        expect_wr(32'h80020005, 32'h00000002, 2'b00);
        expect_wr(32'h80020006, 32'h00000003, 2'b00);
`endif
        put(32'h80020004, 8'h01, 1'b0);
        put(32'h80020005, 8'h02, 1'b0);
        put(32'h80020006, 8'h03, 1'b0);
        do_flush();
        chk("t3_idle", bus.idle, 1);

        // Final byte arriving together with flush completes a word.
        expect_wr(32'h80020008, 32'hA1A2A355, 2'b10);
        put(32'h80020008, 8'hA1, 1'b0);
        put(32'h80020009, 8'hA2, 1'b0);
        put(32'h8002000A, 8'hA3, 1'b0);
        put(32'h8002000B, 8'h55, 1'b1);
        wait_idle("t4_idle");

        // Repeat lane: last write wins.
        expect_wr(32'h80020000, 32'h00000088, 2'b00);
        put(32'h80020000, 8'h77, 1'b0);
        put(32'h80020000, 8'h88, 1'b0);
        do_flush();

        // Top of address space, no carry.
        expect_wr(32'hFFFFFFFC, 32'hC0C1C2C3, 2'b10);
        put(32'hFFFFFFFC, 8'hC0, 1'b0);
        put(32'hFFFFFFFD, 8'hC1, 1'b0);
        put(32'hFFFFFFFE, 8'hC2, 1'b0);
        put(32'hFFFFFFFF, 8'hC3, 1'b0);
        wait_idle("t6_idle");
        expect_wr(32'hFFFFFFFF, 32'h000000EE, 2'b00);
        put(32'hFFFFFFFF, 8'hEE, 1'b0);
        do_flush();

        // Reset in the middle of a drain.
        mon_en = 1'b0;
        put(32'h80020020, 8'h20, 1'b0);
        put(32'h80020021, 8'h21, 1'b0);
        put(32'h80020022, 8'h22, 1'b0);
        put(32'h80020030, 8'h99, 1'b0);
        @(posedge clk);
        #2;
        chk("t7_write_before_rst", bus.write, 1);
        rst_n = 1'b0;
        #1;
        chk("t7_write_async_drop", bus.write, 0);
        chk("t7_idle_in_rst", bus.idle, 1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t7_no_write", bus.write, 0);
        end
        chk("t7_idle_after", bus.idle, 1);
        mon_en = 1'b1;

        chk("sb_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
